// File: rtl/rbcp_arb_pkg.sv
// Shared types and constants for the RBCP requester arbiter.
package rbcp_arb_pkg;

  localparam int unsigned RBCP_ADDR_W = 32;
  localparam int unsigned RBCP_DATA_W = 8;
  localparam logic [RBCP_DATA_W-1:0] ERR_RD_DEFAULT = 8'hEE;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

endpackage

// File: rtl/rbcp_rr_pick.sv
// Rotating-priority encoder: first set pending bit strictly after ptr_i, wrapping modulo N_REQ.
module rbcp_rr_pick #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned j;
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    // Start one past the pointer so the last owner has lowest priority.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j = (32'(ptr_i) + k) % N_REQ;
      if (!valid_o && pending_i[IdxW'(j)]) begin
        valid_o            = 1'b1;
        idx_o              = IdxW'(j);
        pick_o[IdxW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rbcp_arbiter.sv
// Round-robin arbiter sharing one RBCP bridge port between N_REQ RBCP masters.
// Optional `TIMEOUT_EN forces completion of a stalled transaction after TIMEOUT_CYCLES.
module rbcp_arbiter
  import rbcp_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [RBCP_DATA_W-1:0] ERR_RD = ERR_RD_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RBCP_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [RBCP_DATA_W*N_REQ-1:0] req_wd,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ-1:0]             req_re,
  output logic [N_REQ-1:0]             req_ack,
  output logic [RBCP_DATA_W-1:0]       req_rd,
  output logic                         m_act,
  output logic [RBCP_ADDR_W-1:0]       m_addr,
  output logic [RBCP_DATA_W-1:0]       m_wd,
  output logic                         m_we,
  output logic                         m_re,
  input  logic                         m_ack,
  input  logic [RBCP_DATA_W-1:0]       m_rd,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy,
  output logic [N_REQ-1:0]             drop_err,
  output logic [N_REQ-1:0]             timeout_err,
  input  logic                         err_clr
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  state_e                                  state_q, state_d;
  logic [N_REQ-1:0]                        pending_q, pending_d;
  logic [N_REQ-1:0]                        is_wr_q, is_wr_d;
  logic [N_REQ-1:0][RBCP_ADDR_W-1:0]       addr_q, addr_d;
  logic [N_REQ-1:0][RBCP_DATA_W-1:0]       wd_q, wd_d;
  logic [N_REQ-1:0]                        drop_err_q, drop_err_d;
  logic [N_REQ-1:0]                        grant_q, grant_d;
  logic [N_REQ-1:0]                        req_ack_q, req_ack_d;
  logic [IdxW-1:0]                         ptr_q, ptr_d;
  logic [IdxW-1:0]                         gidx_q, gidx_d;
  logic [RBCP_ADDR_W-1:0]                  m_addr_q, m_addr_d;
  logic [RBCP_DATA_W-1:0]                  m_wd_q, m_wd_d;
  logic [RBCP_DATA_W-1:0]                  req_rd_q, req_rd_d;
  logic                                    m_act_q, m_act_d;
  logic                                    m_we_q, m_we_d;
  logic                                    m_re_q, m_re_d;
  logic                                    done;

  logic [N_REQ-1:0]                        pick;
  logic [IdxW-1:0]                         pick_idx;
  logic                                    pick_valid;

  rbcp_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .pending_i(pending_q),
    .ptr_i    (ptr_q),
    .pick_o   (pick),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

`ifdef TIMEOUT_EN
  logic [31:0]      cnt_q, cnt_d;
  logic             timed;
  logic [N_REQ-1:0] timeout_err_q, timeout_err_d;

  assign cnt_d = (state_q == StIdle) ? 32'd0 : cnt_q + 32'd1;

  always_comb begin
    timeout_err_d = err_clr ? '0 : timeout_err_q;
    if (timed) timeout_err_d[gidx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_to_cfg;
  assign unused_to_cfg = ^{ERR_RD, TIMEOUT_CYCLES};
  assign timeout_err   = '0;
`endif

  // Transaction FSM; every bridge-facing output is registered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    m_addr_d  = m_addr_q;
    m_wd_d    = m_wd_q;
    m_act_d   = m_act_q;
    m_we_d    = 1'b0;
    m_re_d    = 1'b0;
    req_ack_d = '0;
    req_rd_d  = '0;
    done      = 1'b0;
`ifdef TIMEOUT_EN
    timed     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d  = pick;
          gidx_d   = pick_idx;
          m_addr_d = addr_q[pick_idx];
          m_wd_d   = wd_q[pick_idx];
          m_act_d  = 1'b1;
          m_we_d   = is_wr_q[pick_idx];
          m_re_d   = !is_wr_q[pick_idx];
          state_d  = StIssue;
        end
      end
      StIssue, StWait: begin
        state_d = StWait;
        if (m_ack) begin
          done     = 1'b1;
          req_rd_d = m_rd;
        end
`ifdef TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          done     = 1'b1;
          timed    = 1'b1;
          req_rd_d = ERR_RD;
        end
`endif
        if (done) begin
          req_ack_d = grant_q;
          ptr_d     = gidx_q;
          grant_d   = '0;
          m_act_d   = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending latches; a pulse landing in the owner's completion cycle is accepted.
  always_comb begin
    pending_d  = pending_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    drop_err_d = err_clr ? '0 : drop_err_q;
    if (done) pending_d[gidx_q] = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_we[i] || req_re[i]) begin
        if ((req_we[i] && req_re[i]) ||
            (pending_q[i] && !(done && gidx_q == IdxW'(i)))) begin
          drop_err_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          is_wr_d[i]   = req_we[i];
          addr_d[i]    = req_addr[RBCP_ADDR_W*i +: RBCP_ADDR_W];
          wd_d[i]      = req_wd[RBCP_DATA_W*i +: RBCP_DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      is_wr_q    <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      drop_err_q <= '0;
      grant_q    <= '0;
      req_ack_q  <= '0;
      ptr_q      <= IdxW'(N_REQ - 1);
      gidx_q     <= '0;
      m_addr_q   <= '0;
      m_wd_q     <= '0;
      req_rd_q   <= '0;
      m_act_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_re_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      drop_err_q <= drop_err_d;
      grant_q    <= grant_d;
      req_ack_q  <= req_ack_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      m_addr_q   <= m_addr_d;
      m_wd_q     <= m_wd_d;
      req_rd_q   <= req_rd_d;
      m_act_q    <= m_act_d;
      m_we_q     <= m_we_d;
      m_re_q     <= m_re_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign req_rd   = req_rd_q;
  assign m_act    = m_act_q;
  assign m_addr   = m_addr_q;
  assign m_wd     = m_wd_q;
  assign m_we     = m_we_q;
  assign m_re     = m_re_q;
  assign grant    = grant_q;
  assign busy     = (state_q != StIdle);
  assign drop_err = drop_err_q;

endmodule
